// File: rtl/fifo_ctrl_regfile.sv
// 8-entry storage and control stage for a first-word-fall-through FIFO.
// Holds the data registers, pointers, occupancy and status; the downstream
// 8:1 mux picks the head word using rd_ptr.
module fifo_ctrl_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [2:0]        rd_ptr,
  output logic              full,
  output logic              empty,
  output logic [3:0]        data_count,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam logic [3:0] FullCount = 4'(DEPTH);

  // State records the action performed at the most recent edge.
  typedef enum logic [2:0] {
    StInit,
    StNoOp,
    StWrite,
    StWrError,
    StRead,
    StRdError
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [2:0]        wr_ptr_q, wr_ptr_d;
  logic [2:0]        rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;

  logic full_w;
  logic empty_w;

  assign full_w  = (count_q == FullCount);
  assign empty_w = (count_q == 4'd0);

  // Decode the action for the coming edge; simultaneous requests are ignored.
  always_comb begin
    state_d = StNoOp;
    unique case ({wr_en, rd_en})
      2'b10:   state_d = full_w  ? StWrError : StWrite;
      2'b01:   state_d = empty_w ? StRdError : StRead;
      default: state_d = StNoOp;
    endcase
  end

  // Datapath next-state: storage, pointers and occupancy follow the decoded action.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (state_d)
      StWrite: begin
        mem_d[wr_ptr_q] = d_in;
        wr_ptr_d        = wr_ptr_q + 3'd1;
        count_d         = count_q + 4'd1;
      end
      StRead: begin
        // Storage is left intact on a pop; only the head index moves.
        rd_ptr_d = rd_ptr_q + 3'd1;
        count_d  = count_q - 4'd1;
      end
      default: begin
      end
    endcase
  end

  // Control FSM state register; reset returns to the initial state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage, pointers and occupancy; reset discards all contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Status strobes decode straight from the state register, so each is
  // high for exactly the one cycle following the edge that took the action.
  assign wr_ack = (state_q == StWrite);
  assign wr_err = (state_q == StWrError);
  assign rd_ack = (state_q == StRead);
  assign rd_err = (state_q == StRdError);

  assign full       = full_w;
  assign empty      = empty_w;
  assign data_count = count_q;
  assign rd_ptr     = rd_ptr_q;

  assign reg0 = mem_q[0];
  assign reg1 = mem_q[1];
  assign reg2 = mem_q[2];
  assign reg3 = mem_q[3];
  assign reg4 = mem_q[4];
  assign reg5 = mem_q[5];
  assign reg6 = mem_q[6];
  assign reg7 = mem_q[7];

  // Occupancy never exceeds capacity.
  assert property (@(posedge clk) disable iff (rst) count_q <= FullCount);

  // Occupancy agrees with the pointer distance; a full queue has equal pointers.
  assert property (@(posedge clk) disable iff (rst)
    (count_q == FullCount) ? (wr_ptr_q == rd_ptr_q)
                           : (count_q == {1'b0, 3'(wr_ptr_q - rd_ptr_q)}));

endmodule

// File: tb/tb_fifo_ctrl_regfile.sv
// Randomized bench for fifo_ctrl_regfile against a queue-based reference model.
module tb_fifo_ctrl_regfile;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] d_in;
  logic [31:0] r [8];
  logic [2:0]  rd_ptr;
  logic        full;
  logic        empty;
  logic [3:0]  data_count;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;

  fifo_ctrl_regfile #(
    .DATA_W(32),
    .DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .d_in      (d_in),
    .reg0      (r[0]),
    .reg1      (r[1]),
    .reg2      (r[2]),
    .reg3      (r[3]),
    .reg4      (r[4]),
    .reg5      (r[5]),
    .reg6      (r[6]),
    .reg7      (r[7]),
    .rd_ptr    (rd_ptr),
    .full      (full),
    .empty     (empty),
    .data_count(data_count),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err),
    .rd_ack    (rd_ack),
    .rd_err    (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Reference model: FIFO contents as a queue, storage slots by write order.
  logic [31:0] q [$];
  logic [31:0] m_mem [8];
  int          m_wp;
  int          m_rp;
  logic        e_wr_ack, e_wr_err, e_rd_ack, e_rd_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_edge(input logic w, input logic rd, input logic [31:0] d, input logic rs);
    e_wr_ack = 1'b0;
    e_wr_err = 1'b0;
    e_rd_ack = 1'b0;
    e_rd_err = 1'b0;
    if (rs) begin
      q.delete();
      for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
      m_wp = 0;
      m_rp = 0;
    end else if (w && !rd) begin
      if (q.size() < 8) begin
        q.push_back(d);
        m_mem[m_wp] = d;
        m_wp = (m_wp + 1) % 8;
        e_wr_ack = 1'b1;
      end else begin
        e_wr_err = 1'b1;
      end
    end else if (rd && !w) begin
      if (q.size() > 0) begin
        void'(q.pop_front());
        m_rp = (m_rp + 1) % 8;
        e_rd_ack = 1'b1;
      end else begin
        e_rd_err = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("data_count", 32'(data_count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == 8));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("rd_ptr", 32'(rd_ptr), 32'(m_rp));
    check("wr_ack", 32'(wr_ack), 32'(e_wr_ack));
    check("wr_err", 32'(wr_err), 32'(e_wr_err));
    check("rd_ack", 32'(rd_ack), 32'(e_rd_ack));
    check("rd_err", 32'(rd_err), 32'(e_rd_err));
    for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), r[i], m_mem[i]);
    // Emulate the downstream mux: the head word must be the oldest queued word.
    if (q.size() > 0) check("head", r[rd_ptr], q[0]);
  endtask

  // Drive one cycle from a negedge, let the posedge act, then compare at the next negedge.
  task automatic step(input logic w, input logic rd, input logic [31:0] d, input logic rs);
    wr_en = w;
    rd_en = rd;
    d_in  = d;
    rst   = rs;
    @(posedge clk);
    model_edge(w, rd, d, rs);
    @(negedge clk);
    cycle++;
    check_all();
  endtask

  initial begin
    logic [31:0] word;
    int          wr_pct;
    wr_en = 1'b0;
    rd_en = 1'b0;
    d_in  = 32'h0;
    rst   = 1'b1;
    m_wp  = 0;
    m_rp  = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;

    // Reset then idle.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Fill with 0x11111111..0x88888888, then one write too many.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'h11111111 * i, 1'b0);
    step(1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    check("reg0_after_full", r[0], 32'h11111111);

    // Drain in order, then one pop too many.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h0, 1'b0);

    // Wrap-around: write 5, read 5, write 6, read 6.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h55 + i, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'hA0 + i, 1'b0);
    check("wrap_reg5", r[5], 32'hA0);
    check("wrap_reg2", r[2], 32'hA5);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h0, 1'b0);

    // Simultaneous requests at count 3 are ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hC0 + i, 1'b0);
    step(1'b1, 1'b1, 32'hCAFE0000, 1'b0);
    step(1'b1, 1'b1, 32'hCAFE0001, 1'b0);

    // Reset during a write at count 4 drops everything.
    step(1'b1, 1'b0, 32'hC3, 1'b0);
    step(1'b1, 1'b0, 32'hBAD0BAD0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic with a drifting write bias and rare resets.
    wr_pct = 50;
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) wr_pct = int'($urandom_range(15, 85));
      word = $urandom;
      step(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) >= wr_pct) ||
           ($urandom_range(0, 9) == 0), word, ($urandom_range(0, 127) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_regfile.md
Name: fifo_ctrl_regfile

Overview:
8-entry x 32-bit FIFO storage and control stage that sits directly upstream of the FIFO's 8-to-1 read multiplexer.
- Holds the eight data registers and the write/read pointers, occupancy count and status flags.
- Drives the eight register contents plus a 3-bit read pointer into the mux. The mux returns the head-of-queue word (first-word-fall-through).

Parameters:
DATA_W, 32, width of each storage entry and of d_in.
DEPTH, 8, number of entries; fixed at 8 to match the 3-bit mux select (PTR_W = 3).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request for this cycle
rd_en  input  1  read (pop) request for this cycle
d_in  input  32  write data
reg0..reg7  output  32 each  storage entry contents, to mux data inputs a..h
rd_ptr  output  3  index of oldest entry, to mux sel
full  output  1  count == 8
empty  output  1  count == 0
data_count  output  4  occupancy, 0..8
wr_ack  output  1  registered; previous edge performed a write
wr_err  output  1  registered; previous edge rejected a write (full)
rd_ack  output  1  registered; previous edge performed a pop
rd_err  output  1  registered; previous edge rejected a pop (empty)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. All state changes occur on the rising edge of clk.
- Reset (rst=1 at edge):
  - reg0..reg7 = 0; wr_ptr = 0; rd_ptr = 0; data_count = 0.
  - State = INIT.
  - wr_ack, wr_err, rd_ack and rd_err = 0.
  - Resulting flags: empty = 1, full = 0.
  - rst overrides any concurrent wr_en/rd_en. Reset mid-operation discards all contents.
- FSM states: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. The state register holds the action taken at the last edge. Next state is decoded from wr_en, rd_en and the current data_count:
  - wr_en=1, rd_en=0, count<8: WRITE.
  - wr_en=1, rd_en=0, count==8: WR_ERROR.
  - wr_en=0, rd_en=1, count>0: READ.
  - wr_en=0, rd_en=1, count==0: RD_ERROR.
  - wr_en=rd_en (both 0 or both 1): NO_OP. Simultaneous requests are ignored, with no ack and no err.
  - INIT is left on the first edge after rst deasserts, using the same decode.
- Actions on the edge that enters each state:
  - WRITE: reg[wr_ptr] <= d_in; wr_ptr <= wr_ptr+1 (mod 8, 7 wraps to 0); data_count +1.
  - READ: rd_ptr <= rd_ptr+1 (mod 8); data_count -1. Storage is not cleared on read.
  - WR_ERROR, RD_ERROR, NO_OP: pointers, count and storage unchanged.
- Status outputs:
  - wr_ack=1 only in state WRITE; wr_err=1 only in WR_ERROR; rd_ack=1 only in READ; rd_err=1 only in RD_ERROR. Each is high for exactly one cycle per accepted or rejected request.
  - full and empty are combinational from data_count.
- Read data path:
  - While empty=0, the head word is reg[rd_ptr] via the downstream mux, valid in the same cycle, i.e. zero read latency. A pop at the edge advances to the next word.
  - While empty=1, the head is the stale entry and must not be consumed.
- Write-to-read latency: a word written at edge N is visible at the mux output after edge N when it becomes the head.
- Invariants:
  - data_count == (wr_ptr - rd_ptr) mod 8, except when count is 8, where wr_ptr == rd_ptr.
  - Never count > 8 or underflow.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, data_count=0, rd_ptr=0, all ack/err=0, reg0..reg7=0.
- Write 0x11111111..0x88888888 on 8 consecutive cycles -> wr_ack high each following cycle, data_count 1..8, full=1 after the 8th; a 9th write of 0xDEADBEEF -> wr_err=1 for one cycle, reg0 still 0x11111111, count 8.
- From full, pop 8 times -> mux output 0x11111111, 0x22222222, ... in order; rd_ptr 0..7 then wraps to 0; empty=1; 9th pop -> rd_err=1, rd_ptr stays 0.
- Wrap-around: write 5, read 5, write 6 (0xA0..0xA5) -> entries land in reg5, reg6, reg7, reg0, reg1, reg2; reads return 0xA0..0xA5 in order with rd_ptr 5, 6, 7, 0, 1, 2.
- wr_en=rd_en=1 with count=3 -> NO_OP: count stays 3, pointers unchanged, no ack/err.
- Assert rst for one cycle at count=4 during a write -> the write is dropped, count=0, empty=1, pointers 0, all storage 0.
